// File: rtl/arm_run_controller.sv
// Run sequencer for the single-cycle ARM core: start-button sync, held reset,
// slow processor clock generation, checkpoint monitoring and PASS/FAIL latching.
module arm_run_controller #(
   parameter int          DIV_W     = 22,
   parameter int          RST_TICKS = 2,
   parameter int          MAX_STEPS = 1024,
   parameter logic [31:0] CHK1_ADR  = 32'h14,
   parameter logic [31:0] CHK2_ADR  = 32'h1A,
   parameter logic [31:0] CHK_DATA  = 32'h7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_n,
   input  logic        mem_we,
   input  logic [31:0] data_adr,
   input  logic [31:0] write_data,
   output logic        cpu_clk,
   output logic        cpu_reset,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic [1:0]  chk_hit,
   output logic [15:0] step_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_RUN  = 3'd2,
      S_PASS = 3'd3,
      S_FAIL = 3'd4
   } state_t;

   localparam logic [15:0] RST_LAST  = 16'(RST_TICKS - 1);
   localparam logic [15:0] STEP_MAX  = 16'(MAX_STEPS);
   localparam logic [15:0] STEP_SAT  = 16'hFFFF;

   state_t            state_r, state_nx_s;
   logic              sync1_r, sync2_r, sync3_r, start_pulse_r;
   logic [DIV_W-1:0]  div_r;
   logic [15:0]       rst_cnt_r, rst_cnt_nx_s;
   logic              tick_s, sample_s, hit1_s, hit2_s, restart_s;
   logic [1:0]        chk_upd_s;
   logic              cpu_clk_r, cpu_clk_nx_s;
   logic              cpu_reset_r, cpu_reset_nx_s;
   logic              busy_r, busy_nx_s, pass_r, pass_nx_s, fail_r, fail_nx_s;
   logic [1:0]        chk_hit_r, chk_hit_nx_s;
   logic [15:0]       step_r, step_nx_s;

   // Button synchronizer and registered falling-edge detector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r       <= 1'b1;
         sync2_r       <= 1'b1;
         sync3_r       <= 1'b1;
         start_pulse_r <= 1'b0;
      end else begin
         sync1_r       <= start_n;
         sync2_r       <= sync1_r;
         sync3_r       <= sync2_r;
         start_pulse_r <= sync3_r & ~sync2_r;
      end
   end

   // Free-running tick divider
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   assign tick_s    = &div_r;
   // Sample point: the tick that drives cpu_clk low, when monitor inputs are settled
   assign sample_s  = (state_r == S_RUN) && tick_s && cpu_clk_r;
   assign hit1_s    = mem_we && (data_adr == CHK1_ADR) && (write_data == CHK_DATA);
   assign hit2_s    = mem_we && (data_adr == CHK2_ADR) && (write_data == CHK_DATA);
   assign chk_upd_s = chk_hit_r | {hit2_s, hit1_s};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start_pulse_r) state_nx_s = S_RST;
            else               state_nx_s = S_IDLE;
         end
         S_RST: begin
            if (tick_s && (rst_cnt_r == RST_LAST)) state_nx_s = S_RUN;
            else                                   state_nx_s = S_RST;
         end
         S_RUN: begin
            if (sample_s && (&chk_upd_s))                 state_nx_s = S_PASS;
            else if (sample_s && (step_r == STEP_MAX))    state_nx_s = S_FAIL;
            else                                          state_nx_s = S_RUN;
         end
         S_PASS, S_FAIL: begin
            if (start_pulse_r) state_nx_s = S_RST;
            else               state_nx_s = state_r;
         end
         default: state_nx_s = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and the reset-tick counter
   always_comb begin
      restart_s      = (state_nx_s == S_RST) && (state_r != S_RST);
      cpu_clk_nx_s   = 1'b0;
      cpu_reset_nx_s = (state_nx_s == S_IDLE) || (state_nx_s == S_RST);
      busy_nx_s      = (state_nx_s == S_RST) || (state_nx_s == S_RUN);
      pass_nx_s      = (state_nx_s == S_PASS);
      fail_nx_s      = (state_nx_s == S_FAIL);
      step_nx_s      = step_r;
      chk_hit_nx_s   = chk_hit_r;
      rst_cnt_nx_s   = rst_cnt_r;
      if ((state_r == S_RUN) && (state_nx_s == S_RUN)) begin
         cpu_clk_nx_s = cpu_clk_r ^ tick_s;
      end else begin
         cpu_clk_nx_s = 1'b0;
      end
      if (restart_s) begin
         step_nx_s    = 16'd0;
         chk_hit_nx_s = 2'b00;
         rst_cnt_nx_s = 16'd0;
      end else if ((state_r == S_RUN) && tick_s && !cpu_clk_r) begin
         step_nx_s = (step_r == STEP_SAT) ? step_r : step_r + 16'd1;
      end else if (sample_s) begin
         chk_hit_nx_s = chk_upd_s;
      end else if ((state_r == S_RST) && tick_s) begin
         rst_cnt_nx_s = rst_cnt_r + 16'd1;
      end else begin
         step_nx_s = step_r;
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_clk_r   <= 1'b0;
         cpu_reset_r <= 1'b1;
         busy_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         chk_hit_r   <= 2'b00;
         step_r      <= 16'd0;
         rst_cnt_r   <= 16'd0;
      end else begin
         cpu_clk_r   <= cpu_clk_nx_s;
         cpu_reset_r <= cpu_reset_nx_s;
         busy_r      <= busy_nx_s;
         pass_r      <= pass_nx_s;
         fail_r      <= fail_nx_s;
         chk_hit_r   <= chk_hit_nx_s;
         step_r      <= step_nx_s;
         rst_cnt_r   <= rst_cnt_nx_s;
      end
   end

   assign cpu_clk    = cpu_clk_r;
   assign cpu_reset  = cpu_reset_r;
   assign busy       = busy_r;
   assign pass       = pass_r;
   assign fail       = fail_r;
   assign chk_hit    = chk_hit_r;
   assign step_count = step_r;

endmodule

// File: doc/arm_run_controller.md
Name: arm_run_controller

Overview:
- Board-level run sequencer for the single-cycle ARM core.
- Turns a push-button start into a controlled run: holds the core in reset, then generates a slow processor clock.
- While running, it monitors data-memory writes for two pass checkpoints, enforces a step-count timeout, and latches the PASS/FAIL result for the LEDs.
- Sits between board clk/buttons and the processor/memory top, replacing ad-hoc counter and latch logic in the board wrapper.

Parameters:
- DIV_W, 22: width of the free-running tick divider; one tick every 2^DIV_W clk cycles.
- RST_TICKS, 2: number of ticks cpu_reset is held in state RST (must be ≥1).
- MAX_STEPS, 1024: processor clock periods allowed before FAIL (must be ≥1 and < 2^16).
- CHK1_ADR, 32'h14: address of checkpoint 1.
- CHK2_ADR, 32'h1A: address of checkpoint 2.
- CHK_DATA, 32'h7: write data required at both checkpoints.

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-high; clock is clk.
- start_n  in  1  raw start button, active-low, asynchronous to clk.
- mem_we  in  1  processor data-memory write enable.
- data_adr  in  32  processor data address.
- write_data  in  32  processor write data.
- cpu_clk  out  1  registered slow clock driving the processor and data memory.
- cpu_reset  out  1  registered reset to the processor, active-high.
- busy  out  1  high in RST or RUN.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- chk_hit  out  2  sticky checkpoint flags: bit0 = checkpoint 1, bit1 = checkpoint 2.
- step_count  out  16  number of cpu_clk rising edges issued since the run started.

Behaviour:
- Reset values: state=IDLE, cpu_clk=0, cpu_reset=1, busy=0, pass=0, fail=0, chk_hit=0, step_count=0, divider=0, synchronizer flops=1.
- start_n passes through a 2-FF synchronizer, then a falling-edge detector. Result: start_pulse, 1 clk wide, asserted 3 clk after the button falls.
- Divider: DIV_W-bit counter, free-running in all states. tick=1 in the clk cycle where divider is all ones.
- All outputs are registered and change only on clk rising edges.
- IDLE: cpu_reset=1, cpu_clk=0. On start_pulse go to RST, clearing chk_hit, step_count and the reset-tick counter.
- RST: cpu_reset=1, cpu_clk=0. Count ticks. On the RST_TICKS-th tick: go to RUN and deassert cpu_reset in the same edge.
- RUN: cpu_reset=0. cpu_clk toggles on every tick.
  - On each 0→1 toggle, step_count increments (saturating at 16'hFFFF).
  - Sample point is a tick with cpu_clk=1, i.e. the edge that drives cpu_clk low; monitor inputs are stable there. At the sample point:
    - mem_we & data_adr==CHK1_ADR & write_data==CHK_DATA sets chk_hit[0].
    - The same test with CHK2_ADR sets chk_hit[1].
    - Flags are sticky and may be set in either order.
  - Exit evaluation uses the values after the current sample's update, and happens only at sample points, so cpu_clk is always left at 0:
    - both chk_hit bits set → PASS.
    - else step_count==MAX_STEPS → FAIL.
    - If both conditions hold at the same sample, PASS wins.
  - start_pulse is ignored in RUN.
- PASS / FAIL: cpu_clk=0, cpu_reset=0 (processor state preserved for inspection). chk_hit and step_count are held.
  - start_pulse → RST; chk_hit and step_count are cleared, pass/fail drop.
- start_pulse during RST is ignored.
- busy, pass and fail are registered decodes of the next state and are mutually exclusive.
- Asynchronous reset at any time returns every register to its reset value, including mid-RUN with cpu_clk=1. cpu_clk falls immediately.
- mem_we, data_adr and write_data are ignored outside RUN sample points.

Test Plan (DIV_W=2 so a tick occurs every 4 clk; RST_TICKS=2; MAX_STEPS=8):
- Reset then idle: assert reset mid-divider, release, hold start_n=1 for 100 clk → cpu_reset=1, cpu_clk=0, busy=0, step_count=0.
- Start sequencing: pulse start_n low for 10 clk →
  - busy=1 four clk after the fall (pulse at 3 clk, state register 1 clk later);
  - cpu_reset stays 1 for exactly 2 ticks, then falls;
  - first cpu_clk rise one tick later; step_count=1 after it.
- Pass path: during RUN, hold mem_we=1, data_adr=0x1A, write_data=7 for period 3, then data_adr=0x14, write_data=7 for period 5 →
  - chk_hit=2'b10 after period 3, then 2'b11;
  - PASS with step_count=5, cpu_clk=0, pass=1, busy=0.
- Near-miss and timeout: write data 6 to 0x14 and data 7 to 0x18 →
  - chk_hit stays 0;
  - FAIL at the sample point of period 8 with step_count=8, fail=1.
- Tie: checkpoint 2 hit in period 2, checkpoint 1 hit in period 8 → PASS, not FAIL, with step_count=8.
- Restart and abort:
  - from FAIL, press start → chk_hit=0, step_count=0, RST entered;
  - start pulse in RUN → no effect;
  - assert reset while cpu_clk=1 → cpu_clk=0, cpu_reset=1, state IDLE on the same edge.
